s100_bus_cycle_gen: RTL and testbench
=====================================

# s100_bus_cycle_gen

Bus-cycle sequencer that turns a single-transfer request (address, data, read/write, memory/IO) into a correctly ordered S-100 master cycle. It drives the address, status, strobe and data-out lines that the SBC output buffers place on the bus, and it replaces the free-running counter and fake strobes used during board bring-up. It samples the bus ready lines to insert wait states and returns read data plus a completion pulse to the requesting logic.

## Interface
- MIN_WAIT, 0, wait states always inserted in T2 (0–15)
- TIMEOUT, 255, maximum wait states before the cycle is forced to complete (1–255)

- pll0_2MHz  in  1  bus clock; all logic on rising edge
- s100_RESET  in  1  synchronous, active-high reset
- req  in  1  start a cycle; accepted only when busy=0
- req_addr  in  20  cycle address A19..A0
- req_data  in  8  write data
- req_write  in  1  1=write, 0=read
- req_io  in  1  1=I/O cycle, 0=memory cycle
- s100_PRDY, s100_XRDY  in  1 each  bus ready; both must be high to proceed
- s100_DI  in  8  S-100 data-in bus
- busy  out  1  high from the cycle after acceptance until the cycle after T3
- done  out  1  one-cycle pulse in T3
- err  out  1  valid with done; 1 = cycle ended on timeout
- rd_data  out  8  read data, held until the next read completes
- s100_A  out  20  address bus, plain bit order A19..A0
- s100_DO  out  8  data-out bus
- s100_pSYNC, s100_pSTVAL, s100_pDBIN, s100_n_pWR  out  1 each  bus strobes; pSTVAL and n_pWR are active low
- s100_sMEMR, s100_sMWRT, s100_sINP, s100_sOUT  out  1 each  status lines

## Operation
- States: IDLE, T1, T1S, T2, TW, T3.
- IDLE: when req=1, latch req_addr, req_data, req_write and req_io, then go to T1. A req that arrives while busy=1 is ignored; there is no queue.
- T1: pSYNC=1 and status is valid. Next state is T1S.
- T1S: pSYNC=1 and pSTVAL=0. Next state is T2.
- T2 and TW:
  - Read cycle: pDBIN=1.
  - Write cycle: n_pWR=0.
  - The 8-bit wait counter resets on entry to T2 and increments once per cycle spent in T2 or TW.
  - Proceed to T3 when PRDY=1, XRDY=1 and the counter ≥ MIN_WAIT. Otherwise go to (or stay in) TW.
  - If the counter reaches TIMEOUT before those conditions are met, go to T3 with err=1.
- Read data capture: on the edge that leaves T2/TW into T3, rd_data <= s100_DI. On a timeout, rd_data <= 8'hFF instead.
- T3: all strobes inactive; s100_A and status are still held; done=1. Next state is IDLE.
- Status decode, held T1 through T3:
  - sMEMR = !io & !write
  - sMWRT = !io & write
  - sINP = io & !write
  - sOUT = io & write
- Status in IDLE: all four status lines = 0.
- s100_A and s100_DO hold the last latched values in IDLE. s100_DO is driven with req_data on write cycles and holds its previous value on read cycles.
- Registered outputs: every output is registered, with no combinational path from inputs to outputs.

## Timing
- Reset (s100_RESET=1 at a rising edge) takes effect at that edge, from any state, including mid-cycle:
  - state = IDLE
  - pSYNC=0, pSTVAL=1, pDBIN=0, n_pWR=1
  - all status lines = 0
  - s100_A=0, s100_DO=0, rd_data=0
  - busy=0, done=0, err=0
  - No done is issued for an aborted cycle.
- Zero-wait cycle (req sampled high at edge 0):
  - edge 1 → T1
  - edge 2 → T1S
  - edge 3 → T2
  - edge 4 → T3 (done=1)
  - edge 5 → IDLE (busy=0)
  - A new req may be sampled at edge 5.
- Wait states: each cycle of ready-low or of MIN_WAIT adds one TW cycle. Total cycle length is 4 + max(MIN_WAIT, ready delay) clock periods.
- Ready is sampled at the edge that ends T2 or TW. A ready pulse in any earlier state is ignored.
- err: valid only while done=1; otherwise 0.
- Strobe overlap: pDBIN and n_pWR are never active in the same cycle. pSYNC is never active together with pDBIN or n_pWR.

## Test plan
- Reset, then a memory read of 0x12345 with PRDY=XRDY=1 and s100_DI=0xA5 → done at the 4th edge after req, rd_data=0xA5, sMEMR=1 from T1 through T3, pDBIN high only in T2, err=0.
- I/O write of 0x0007F with data 0x3C → sOUT=1, n_pWR=0 for exactly one cycle, s100_DO=0x3C, s100_A=0x0007F, done pulse one cycle wide, busy low at edge 5.
- Memory write with XRDY held low for 3 cycles → exactly 3 TW cycles, n_pWR low for 4 cycles total, done at edge 7.
- TIMEOUT=4 with PRDY stuck low on a read → T3 after 4 waits, done=1, err=1, rd_data=0xFF.
- req pulsed during TW of an active cycle → ignored; busy drops, no second cycle starts. Then a fresh req after IDLE is accepted normally.
- s100_RESET asserted during TW → all outputs at their reset values on the next edge, no done pulse, and the next req runs a normal cycle.

Source files
------------

// File: rtl/s100_bus_cycle_gen_if.sv
// Request/response and S-100 bus signals of the master cycle sequencer.
// The master modport is the sequencer; the slave modport is the requester plus bus side.
interface s100_bus_cycle_gen_if;
  logic        req;
  logic [19:0] req_addr;
  logic [7:0]  req_data;
  logic        req_write;
  logic        req_io;
  logic        s100_PRDY;
  logic        s100_XRDY;
  logic [7:0]  s100_DI;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  rd_data;
  logic [19:0] s100_A;
  logic [7:0]  s100_DO;
  logic        s100_pSYNC;
  logic        s100_pSTVAL;
  logic        s100_pDBIN;
  logic        s100_n_pWR;
  logic        s100_sMEMR;
  logic        s100_sMWRT;
  logic        s100_sINP;
  logic        s100_sOUT;

  modport master (
    input  req, req_addr, req_data, req_write, req_io, s100_PRDY, s100_XRDY, s100_DI,
    output busy, done, err, rd_data, s100_A, s100_DO,
           s100_pSYNC, s100_pSTVAL, s100_pDBIN, s100_n_pWR,
           s100_sMEMR, s100_sMWRT, s100_sINP, s100_sOUT
  );

  modport slave (
    output req, req_addr, req_data, req_write, req_io, s100_PRDY, s100_XRDY, s100_DI,
    input  busy, done, err, rd_data, s100_A, s100_DO,
           s100_pSYNC, s100_pSTVAL, s100_pDBIN, s100_n_pWR,
           s100_sMEMR, s100_sMWRT, s100_sINP, s100_sOUT
  );
endinterface

// File: rtl/s100_bus_cycle_gen.sv
// S-100 master bus-cycle sequencer: IDLE -> T1 -> T1S -> T2 -> (TW)* -> T3.
// All outputs are registered from the next-state decode.
module s100_bus_cycle_gen #(
  parameter int MIN_WAIT = 0,
  parameter int TIMEOUT  = 255
) (
  input logic                  pll0_2MHz,
  input logic                  s100_RESET,
  s100_bus_cycle_gen_if.master bus
);
  typedef enum logic [2:0] {IDLE, T1, T1S, T2, TW, T3} state_t;

  localparam logic [7:0] MIN_W = 8'(MIN_WAIT);
  localparam logic [7:0] TMO_W = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic       pend, lat_write, lat_io, tmo, accept, rdy, wait_st;
  logic       nxt_wait, nxt_stat;
  logic [7:0] cnt;

  assign rdy      = bus.s100_PRDY & bus.s100_XRDY;
  assign wait_st  = (state == T2) || (state == TW);
  assign nxt_wait = (state_nxt == T2) || (state_nxt == TW);
  assign nxt_stat = (state_nxt != IDLE);
  // Request is latched one cycle ahead of T1; pend marks that hand-off cycle.
  assign accept   = bus.req && (state == IDLE) && !pend;

  always_ff @(posedge pll0_2MHz) begin
    if (s100_RESET) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmo       = 1'b0;
    case (state)
      IDLE: if (pend) state_nxt = T1;
      T1:   state_nxt = T1S;
      T1S:  state_nxt = T2;
      T2, TW: begin
        if (rdy && cnt >= MIN_W) state_nxt = T3;
        else if (cnt >= TMO_W) begin
          state_nxt = T3;
          tmo       = 1'b1;
        end else state_nxt = TW;
      end
      T3:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pll0_2MHz) begin
    if (s100_RESET) begin
      pend            <= 1'b0;
      lat_write       <= 1'b0;
      lat_io          <= 1'b0;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
      bus.rd_data     <= '0;
      bus.s100_A      <= '0;
      bus.s100_DO     <= '0;
      bus.s100_pSYNC  <= 1'b0;
      bus.s100_pSTVAL <= 1'b1;
      bus.s100_pDBIN  <= 1'b0;
      bus.s100_n_pWR  <= 1'b1;
      bus.s100_sMEMR  <= 1'b0;
      bus.s100_sMWRT  <= 1'b0;
      bus.s100_sINP   <= 1'b0;
      bus.s100_sOUT   <= 1'b0;
    end else begin
      pend <= accept;
      if (accept) begin
        lat_write  <= bus.req_write;
        lat_io     <= bus.req_io;
        bus.s100_A <= bus.req_addr;
        if (bus.req_write) bus.s100_DO <= bus.req_data;
      end
      if (state_nxt == T2) cnt <= '0;
      else if (wait_st)    cnt <= cnt + 8'd1;

      bus.busy <= accept || nxt_stat;
      bus.done <= (state_nxt == T3);
      bus.err  <= tmo;
      if (wait_st && state_nxt == T3 && !lat_write)
        bus.rd_data <= tmo ? 8'hFF : bus.s100_DI;

      bus.s100_pSYNC  <= (state_nxt == T1) || (state_nxt == T1S);
      bus.s100_pSTVAL <= (state_nxt != T1S);
      bus.s100_pDBIN  <= nxt_wait && !lat_write;
      bus.s100_n_pWR  <= !(nxt_wait && lat_write);
      bus.s100_sMEMR  <= nxt_stat && !lat_io && !lat_write;
      bus.s100_sMWRT  <= nxt_stat && !lat_io &&  lat_write;
      bus.s100_sINP   <= nxt_stat &&  lat_io && !lat_write;
      bus.s100_sOUT   <= nxt_stat &&  lat_io &&  lat_write;
    end
  end
endmodule

// File: tb/tb_s100_bus_cycle_gen.sv
// Directed bench for s100_bus_cycle_gen (TIMEOUT=4 so timeout cases stay short).
module tb_s100_bus_cycle_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  s100_bus_cycle_gen_if b ();
  s100_bus_cycle_gen #(.MIN_WAIT(0), .TIMEOUT(4)) dut (
    .pll0_2MHz (clk),
    .s100_RESET(rst),
    .bus       (b.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] stat();
    return {b.s100_sMEMR, b.s100_sMWRT, b.s100_sINP, b.s100_sOUT};
  endfunction

  function automatic logic [3:0] strb();
    return {b.s100_pSYNC, b.s100_pSTVAL, b.s100_pDBIN, b.s100_n_pWR};
  endfunction

  // Drive a request so it is sampled at the next edge (edge 0), then drop it.
  task automatic start(input logic [19:0] a, input logic [7:0] d, input logic w, input logic io);
    b.req_addr = a; b.req_data = d; b.req_write = w; b.req_io = io; b.req = 1'b1;
    tick();
    b.req = 1'b0;
  endtask

  // Watch 12 edges after edge 0; ready lines go high after edge rel.
  task automatic run(input int rel, output int dedge, output int ndone, output logic erra,
                     output int nwr, output int ndbin, output int ovl);
    dedge = 0; ndone = 0; erra = 1'b0; nwr = 0; ndbin = 0; ovl = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (b.done) begin
        ndone++;
        if (dedge == 0) dedge = e;
        erra = b.err;
      end
      if (!b.s100_n_pWR) nwr++;
      if (b.s100_pDBIN)  ndbin++;
      if ((b.s100_pDBIN && !b.s100_n_pWR) ||
          (b.s100_pSYNC && (b.s100_pDBIN || !b.s100_n_pWR))) ovl++;
      if (e == rel) begin
        b.s100_PRDY = 1'b1;
        b.s100_XRDY = 1'b1;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_strb"}, 32'(strb()), 32'b0101);
    chk({tag, "_stat"}, 32'(stat()), 32'h0);
    chk({tag, "_A"}, 32'(b.s100_A), 32'h0);
    chk({tag, "_DO"}, 32'(b.s100_DO), 32'h0);
    chk({tag, "_rd"}, 32'(b.rd_data), 32'h0);
    chk({tag, "_bde"}, 32'({b.busy, b.done, b.err}), 32'h0);
  endtask

  int   dedge, ndone, nwr, ndbin, ovl, seen;
  logic erra;

  initial begin
    b.req = 0; b.req_addr = '0; b.req_data = '0; b.req_write = 0; b.req_io = 0;
    b.s100_PRDY = 1; b.s100_XRDY = 1; b.s100_DI = 8'hA5;
    tick(); tick();
    rst = 1'b0;
    chk_reset_vals("rst");

    // Memory read, zero wait
    start(20'h12345, 8'h00, 1'b0, 1'b0);
    chk("rd_e0_busy", 32'(b.busy), 32'h1);
    tick();
    chk("rd_e1_strb", 32'(strb()), 32'b1101);
    chk("rd_e1_stat", 32'(stat()), 32'b1000);
    chk("rd_e1_A", 32'(b.s100_A), 32'h12345);
    tick();
    chk("rd_e2_strb", 32'(strb()), 32'b1001);
    tick();
    chk("rd_e3_strb", 32'(strb()), 32'b0111);
    chk("rd_e3_done", 32'(b.done), 32'h0);
    tick();
    chk("rd_e4_strb", 32'(strb()), 32'b0101);
    chk("rd_e4_de", 32'({b.done, b.err}), 32'b10);
    chk("rd_e4_stat", 32'(stat()), 32'b1000);
    chk("rd_e4_data", 32'(b.rd_data), 32'hA5);
    tick();
    chk("rd_e5_bd", 32'({b.busy, b.done}), 32'b00);
    chk("rd_e5_stat", 32'(stat()), 32'h0);
    chk("rd_e5_A_held", 32'(b.s100_A), 32'h12345);

    // I/O write, zero wait
    start(20'h0007F, 8'h3C, 1'b1, 1'b1);
    tick(); tick();
    chk("io_e2_stat", 32'(stat()), 32'b0001);
    chk("io_e2_A", 32'(b.s100_A), 32'h0007F);
    chk("io_e2_DO", 32'(b.s100_DO), 32'h3C);
    tick();
    chk("io_e3_strb", 32'(strb()), 32'b0100);
    tick();
    chk("io_e4_strb", 32'(strb()), 32'b0101);
    chk("io_e4_done", 32'(b.done), 32'h1);
    tick();
    chk("io_e5_bd", 32'({b.busy, b.done}), 32'b00);
    chk("io_e5_rd_held", 32'(b.rd_data), 32'hA5);

    // Memory write with XRDY low for three wait samples
    b.s100_XRDY = 1'b0;
    start(20'h0F0F0, 8'h99, 1'b1, 1'b0);
    run(6, dedge, ndone, erra, nwr, ndbin, ovl);
    chk("xw_done_edge", 32'(dedge), 32'd7);
    chk("xw_ndone", 32'(ndone), 32'd1);
    chk("xw_nwr_cycles", 32'(nwr), 32'd4);
    chk("xw_err", 32'(erra), 32'h0);
    chk("xw_ovl", 32'(ovl), 32'd0);
    chk("xw_DO", 32'(b.s100_DO), 32'h99);

    // Read timeout: PRDY stuck low
    b.s100_PRDY = 1'b0; b.s100_DI = 8'h5A;
    start(20'h00200, 8'h00, 1'b0, 1'b0);
    run(20, dedge, ndone, erra, nwr, ndbin, ovl);
    chk("to_done_edge", 32'(dedge), 32'd8);
    chk("to_err", 32'(erra), 32'h1);
    chk("to_rd_data", 32'(b.rd_data), 32'hFF);
    chk("to_ndbin", 32'(ndbin), 32'd5);
    chk("to_DO_kept", 32'(b.s100_DO), 32'h99);
    b.s100_PRDY = 1'b1;

    // Request during TW is ignored
    b.s100_PRDY = 1'b0; b.s100_DI = 8'h11;
    start(20'h00100, 8'h00, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
    b.req_addr = 20'h0ABCD; b.req = 1'b1;
    tick();
    b.req = 1'b0; b.s100_PRDY = 1'b1;
    tick();
    chk("ign_e6_done", 32'(b.done), 32'h1);
    chk("ign_e6_rd", 32'(b.rd_data), 32'h11);
    tick();
    chk("ign_e7_busy", 32'(b.busy), 32'h0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (b.busy || b.s100_pSYNC) seen++;
    end
    chk("ign_no_cycle", 32'(seen), 32'd0);
    chk("ign_A_kept", 32'(b.s100_A), 32'h00100);
    b.s100_DI = 8'h77;
    start(20'h0ABCD, 8'h00, 1'b0, 1'b0);
    run(0, dedge, ndone, erra, nwr, ndbin, ovl);
    chk("fresh_done_edge", 32'(dedge), 32'd4);
    chk("fresh_A", 32'(b.s100_A), 32'h0ABCD);
    chk("fresh_rd", 32'(b.rd_data), 32'h77);

    // Reset during TW
    b.s100_PRDY = 1'b0;
    start(20'h54321, 8'h00, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
    chk("mid_in_tw", 32'(b.s100_pDBIN), 32'h1);
    rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b0; b.s100_PRDY = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b.done) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    b.s100_DI = 8'hC3;
    start(20'h00042, 8'h00, 1'b0, 1'b1);
    run(0, dedge, ndone, erra, nwr, ndbin, ovl);
    chk("post_done_edge", 32'(dedge), 32'd4);
    chk("post_rd", 32'(b.rd_data), 32'hC3);
    chk("post_ndbin", 32'(ndbin), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
